rx_link_fault_mch: RTL and testbench
====================================

Name: rx_link_fault_mch

Overview:
- Multi-channel, parametrised successor to the receive-side link fault signalling state machine (IEEE 802.3 clause 46 Reconciliation Sublayer).
- Sits after the XGMII column decoder: one column per channel per valid cycle, with sequence ordered-set detection supplied.
- Per channel: qualifies local/remote fault sequences with a programmable consecutive-count threshold.
- Clears faults after a programmable number of sequence-free columns.
- Drives TX RS control (send remote fault / send idle) and keeps a saturating fault-event counter.

Parameters:
- NUM_CH, 1: number of independent channels.
- SEQ_THRESH, 4: consecutive same-type sequences needed to declare a fault (range 2..15).
- COL_LIMIT, 128: sequence-free valid columns needed to clear (range 2..1024).
- FCNT_W, 16: width of each fault-event counter.
- Internal counter widths are derived with $clog2 of SEQ_THRESH and COL_LIMIT.

Ports:
- rxclk  in  1  clock.
- reset  in  1  **synchronous, active-high reset**.
- col_valid  in  NUM_CH  column present on channel i this cycle. When 0, channel i holds all state.
- seq_valid  in  NUM_CH  column is a sequence ordered set.
- seq_type  in  2*NUM_CH  bits [2i+1:2i]: 01 local fault, 10 remote fault. 00 and 11 are invalid.
- fcnt_clr  in  NUM_CH  synchronous clear of fault counter i.
- link_fault  out  2*NUM_CH  00 OK, 01 local, 10 remote. Registered.
- send_rf  out  NUM_CH  TX must send Remote Fault (link_fault==01).
- send_idle  out  NUM_CH  TX must send Idle (link_fault==10).
- fault_chg  out  NUM_CH  1-cycle pulse when link_fault_i changes value.
- any_fault  out  1  OR over channels of link_fault!=00.
- fault_cnt  out  FCNT_W*NUM_CH  saturating count of fault declarations.

Behaviour:
- Reset: every channel goes to OK. All counters are 0 and last_type is 00. All outputs are 0.
- A "qualified sequence" is col_valid & seq_valid & seq_type∈{01,10}.
- Columns with seq_valid but an invalid type count as sequence-free.
- All transitions below happen only when col_valid_i=1.
- State OK (link_fault=00):
  - Qualified sequence → COUNT. Set seq_cnt=1, last_type=type, col_cnt=0.
  - Anything else: no change.
- State COUNT:
  - Qualified sequence with type==last_type: seq_cnt+1 and col_cnt=0. If seq_cnt+1==SEQ_THRESH → FAULT, link_fault<=last_type, fault_cnt+1.
  - Qualified sequence with a different type: seq_cnt=1, last_type=new type, col_cnt=0. Stay in COUNT.
  - Sequence-free column: col_cnt+1. If col_cnt+1==COL_LIMIT → OK, link_fault<=00, seq_cnt=0.
- State FAULT (link_fault=last_type):
  - Same-type sequence: col_cnt=0.
  - Different-type sequence → COUNT with seq_cnt=1 and last_type=new type. link_fault keeps the old value until the new type is confirmed; it then changes directly (e.g. 01→10) with no OK gap.
  - Sequence-free column: col_cnt+1. At COL_LIMIT → OK, link_fault<=00.
- Latency: link_fault changes on the rxclk edge that samples the triggering column (1 cycle). send_rf, send_idle and any_fault are combinational from the registered link_fault.
- fault_chg is registered and asserts in the same cycle link_fault shows its new value.
- fault_cnt:
  - Increments on every entry into FAULT, including a type change.
  - Saturates at all-ones.
  - fcnt_clr has priority over a same-cycle increment (result 0).
- Counter rules:
  - col_cnt never exceeds COL_LIMIT-1.
  - seq_cnt never exceeds SEQ_THRESH-1.
  - No wrap-around.
- Reset asserted mid-sequence discards partial counts immediately. The next cycle is OK with all outputs 0.
- Channels are fully independent; no cross-channel interaction except any_fault.

Decomposition:
- Shared package rx_lf_pkg holds:
  - LF_OK=2'b00, LF_LOCAL=2'b01, LF_REMOTE=2'b10;
  - state enum {ST_OK, ST_COUNT, ST_FAULT};
  - a function classifying seq_type as valid/invalid.
- One sub-module, rx_link_fault_ch: single-channel FSM, counters and fault counter, carrying SEQ_THRESH, COL_LIMIT and FCNT_W.
- The top generates NUM_CH instances and ORs any_fault.

Test Plan:
- Qualification: NUM_CH=1, defaults; 4 consecutive local sequences → link_fault=01 one cycle after the 4th, send_rf=1, fault_chg pulse, fault_cnt=1. With only 3 sequences then 128 idle columns, link_fault stays 00.
- Clear timing: fault held, then 127 idle columns → still 01. The 128th → 00, fault_chg pulse. Columns with col_valid=0 interleaved do not advance col_cnt.
- Type change: local fault established, then 3 remote sequences → stays 01. The 4th → 10 directly, send_idle=1, fault_cnt=2. Alternating 01/10 sequences never reach FAULT.
- Invalid types: seq_type=11 with seq_valid=1 repeated 200 times from OK → link_fault 00. In FAULT, 128 such columns clear the fault.
- Multi-channel and counters: NUM_CH=4, FCNT_W=2, SEQ_THRESH=2.
  - Channel 2 faults 5 times → fault_cnt_2=3 (saturated). Other channels stay 00. any_fault=1.
  - fcnt_clr together with an increment → 0.
- Reset mid-operation: reset asserted after 3 same-type sequences, then 1 more sequence → no fault. Full reset state is observed.

Source files
------------

// File: rtl/rx_lf_pkg.sv
// Shared types and constants for the receive-side link fault state machine.
package rx_lf_pkg;

    localparam logic [1:0] LF_OK     = 2'b00;
    localparam logic [1:0] LF_LOCAL  = 2'b01;
    localparam logic [1:0] LF_REMOTE = 2'b10;

    typedef enum logic [1:0] {
        ST_OK,
        ST_COUNT,
        ST_FAULT
    } lf_state_e;

    // Only local and remote fault codes are meaningful sequence types.
    function automatic logic seq_type_valid(input logic [1:0] t);
        return (t == LF_LOCAL) || (t == LF_REMOTE);
    endfunction

endpackage

// File: rtl/rx_link_fault_ch.sv
// Single-channel link fault qualifier: sequence/column counters, fault state
// and saturating fault-event counter.
module rx_link_fault_ch
    import rx_lf_pkg::*;
#(
    parameter int unsigned SEQ_THRESH = 4,
    parameter int unsigned COL_LIMIT  = 128,
    parameter int unsigned FCNT_W     = 16
) (
    input  logic              rxclk,
    input  logic              reset,
    input  logic              col_valid,
    input  logic              seq_valid,
    input  logic [1:0]        seq_type,
    input  logic              fcnt_clr,
    output logic [1:0]        link_fault,
    output logic              send_rf,
    output logic              send_idle,
    output logic              fault_chg,
    output logic [FCNT_W-1:0] fault_cnt
);

    localparam int unsigned SW = $clog2(SEQ_THRESH);
    localparam int unsigned CW = $clog2(COL_LIMIT);
    localparam logic [SW-1:0] SEQ_LAST = SW'(SEQ_THRESH - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COL_LIMIT - 1);

    lf_state_e         state_q, state_d;
    logic [SW-1:0]     seq_cnt_q, seq_cnt_d;
    logic [CW-1:0]     col_cnt_q, col_cnt_d;
    logic [1:0]        last_type_q, last_type_d;
    logic [1:0]        link_fault_q, link_fault_d;
    logic              fault_chg_q;
    logic [FCNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic              qual, same, enter_fault;

    always_ff @(posedge rxclk) begin
        if (reset) begin
            state_q      <= ST_OK;
            seq_cnt_q    <= '0;
            col_cnt_q    <= '0;
            last_type_q  <= LF_OK;
            link_fault_q <= LF_OK;
            fault_chg_q  <= 1'b0;
            fault_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            seq_cnt_q    <= seq_cnt_d;
            col_cnt_q    <= col_cnt_d;
            last_type_q  <= last_type_d;
            link_fault_q <= link_fault_d;
            fault_chg_q  <= (link_fault_d != link_fault_q);
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    always_comb begin
        qual         = col_valid & seq_valid & seq_type_valid(seq_type);
        same         = (seq_type == last_type_q);
        state_d      = state_q;
        seq_cnt_d    = seq_cnt_q;
        col_cnt_d    = col_cnt_q;
        last_type_d  = last_type_q;
        link_fault_d = link_fault_q;
        enter_fault  = 1'b0;
        if (col_valid) begin
            unique case (state_q)
                ST_OK: begin
                    if (qual) begin
                        state_d     = ST_COUNT;
                        seq_cnt_d   = SW'(1);
                        last_type_d = seq_type;
                        col_cnt_d   = '0;
                    end
                end
                ST_COUNT: begin
                    if (qual && same) begin
                        col_cnt_d = '0;
                        if (seq_cnt_q == SEQ_LAST) begin
                            state_d      = ST_FAULT;
                            link_fault_d = last_type_q;
                            seq_cnt_d    = '0;
                            enter_fault  = 1'b1;
                        end else begin
                            seq_cnt_d = seq_cnt_q + SW'(1);
                        end
                    end else if (qual) begin
                        seq_cnt_d   = SW'(1);
                        last_type_d = seq_type;
                        col_cnt_d   = '0;
                    end else if (col_cnt_q == COL_LAST) begin
                        state_d      = ST_OK;
                        link_fault_d = LF_OK;
                        seq_cnt_d    = '0;
                        col_cnt_d    = '0;
                    end else begin
                        col_cnt_d = col_cnt_q + CW'(1);
                    end
                end
                ST_FAULT: begin
                    if (qual && same) begin
                        col_cnt_d = '0;
                    end else if (qual) begin
                        // Old fault stays visible until the new type is confirmed.
                        state_d     = ST_COUNT;
                        seq_cnt_d   = SW'(1);
                        last_type_d = seq_type;
                        col_cnt_d   = '0;
                    end else if (col_cnt_q == COL_LAST) begin
                        state_d      = ST_OK;
                        link_fault_d = LF_OK;
                        seq_cnt_d    = '0;
                        col_cnt_d    = '0;
                    end else begin
                        col_cnt_d = col_cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_OK;
            endcase
        end

        fault_cnt_d = fault_cnt_q;
        if (fcnt_clr) begin
            fault_cnt_d = '0;
        end else if (enter_fault && (fault_cnt_q != '1)) begin
            fault_cnt_d = fault_cnt_q + FCNT_W'(1);
        end
    end

    always_comb begin
        link_fault = link_fault_q;
        send_rf    = (link_fault_q == LF_LOCAL);
        send_idle  = (link_fault_q == LF_REMOTE);
        fault_chg  = fault_chg_q;
        fault_cnt  = fault_cnt_q;
    end

endmodule

// File: rtl/rx_link_fault_mch.sv
// Multi-channel receive link fault signalling: one independent qualifier per
// channel plus an aggregated fault flag.
module rx_link_fault_mch
    import rx_lf_pkg::*;
#(
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned SEQ_THRESH = 4,
    parameter int unsigned COL_LIMIT  = 128,
    parameter int unsigned FCNT_W     = 16
) (
    input  logic                     rxclk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        col_valid,
    input  logic [NUM_CH-1:0]        seq_valid,
    input  logic [2*NUM_CH-1:0]      seq_type,
    input  logic [NUM_CH-1:0]        fcnt_clr,
    output logic [2*NUM_CH-1:0]      link_fault,
    output logic [NUM_CH-1:0]        send_rf,
    output logic [NUM_CH-1:0]        send_idle,
    output logic [NUM_CH-1:0]        fault_chg,
    output logic                     any_fault,
    output logic [FCNT_W*NUM_CH-1:0] fault_cnt
);

    logic [NUM_CH-1:0] ch_fault;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rx_link_fault_ch #(
            .SEQ_THRESH (SEQ_THRESH),
            .COL_LIMIT  (COL_LIMIT),
            .FCNT_W     (FCNT_W)
        ) u_ch (
            .rxclk      (rxclk),
            .reset      (reset),
            .col_valid  (col_valid[i]),
            .seq_valid  (seq_valid[i]),
            .seq_type   (seq_type[2*i +: 2]),
            .fcnt_clr   (fcnt_clr[i]),
            .link_fault (link_fault[2*i +: 2]),
            .send_rf    (send_rf[i]),
            .send_idle  (send_idle[i]),
            .fault_chg  (fault_chg[i]),
            .fault_cnt  (fault_cnt[FCNT_W*i +: FCNT_W])
        );
        assign ch_fault[i] = (link_fault[2*i +: 2] != LF_OK);
    end

    assign any_fault = |ch_fault;

endmodule

// File: tb/tb_rx_link_fault_mch.sv
// Directed bench: single-channel default instance plus a 4-channel instance
// with a narrow fault counter and threshold of 2.
module tb_rx_link_fault_mch;

    logic rxclk = 1'b0;
    logic reset = 1'b0;
    always #5 rxclk = ~rxclk;

    // Single-channel instance
    logic        s_col_valid = 1'b0, s_seq_valid = 1'b0, s_fcnt_clr = 1'b0;
    logic [1:0]  s_seq_type = 2'b00;
    logic [1:0]  s_link_fault;
    logic        s_send_rf, s_send_idle, s_fault_chg, s_any_fault;
    logic [15:0] s_fault_cnt;

    // Four-channel instance
    logic [3:0]  m_col_valid = '0, m_seq_valid = '0, m_fcnt_clr = '0;
    logic [7:0]  m_seq_type = '0;
    logic [7:0]  m_link_fault;
    logic [3:0]  m_send_rf, m_send_idle, m_fault_chg;
    logic        m_any_fault;
    logic [7:0]  m_fault_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    rx_link_fault_mch dut (
        .rxclk      (rxclk),
        .reset      (reset),
        .col_valid  (s_col_valid),
        .seq_valid  (s_seq_valid),
        .seq_type   (s_seq_type),
        .fcnt_clr   (s_fcnt_clr),
        .link_fault (s_link_fault),
        .send_rf    (s_send_rf),
        .send_idle  (s_send_idle),
        .fault_chg  (s_fault_chg),
        .any_fault  (s_any_fault),
        .fault_cnt  (s_fault_cnt)
    );

    rx_link_fault_mch #(
        .NUM_CH     (4),
        .SEQ_THRESH (2),
        .COL_LIMIT  (128),
        .FCNT_W     (2)
    ) dut4 (
        .rxclk      (rxclk),
        .reset      (reset),
        .col_valid  (m_col_valid),
        .seq_valid  (m_seq_valid),
        .seq_type   (m_seq_type),
        .fcnt_clr   (m_fcnt_clr),
        .link_fault (m_link_fault),
        .send_rf    (m_send_rf),
        .send_idle  (m_send_idle),
        .fault_chg  (m_fault_chg),
        .any_fault  (m_any_fault),
        .fault_cnt  (m_fault_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // One column on the single-channel instance; outputs settle #1 after the edge.
    task automatic s_col(input logic cv, input logic sv, input logic [1:0] t);
        @(negedge rxclk);
        s_col_valid = cv;
        s_seq_valid = sv;
        s_seq_type  = t;
        @(posedge rxclk);
        #1;
    endtask

    task automatic m_col(input logic [3:0] cv, input logic [3:0] sv, input logic [7:0] t,
                         input logic [3:0] clr);
        @(negedge rxclk);
        m_col_valid = cv;
        m_seq_valid = sv;
        m_seq_type  = t;
        m_fcnt_clr  = clr;
        @(posedge rxclk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge rxclk);
        reset = 1'b1;
        @(posedge rxclk);
        #1;
        @(negedge rxclk);
        reset = 1'b0;
    endtask

    task automatic check_s(input string tag, input logic [1:0] lf, input logic chg,
                           input logic [15:0] cnt);
        check_eq({tag, ".lf"}, 32'(s_link_fault), 32'(lf));
        check_eq({tag, ".rf"}, 32'(s_send_rf), 32'(lf == 2'b01));
        check_eq({tag, ".idle"}, 32'(s_send_idle), 32'(lf == 2'b10));
        check_eq({tag, ".any"}, 32'(s_any_fault), 32'(lf != 2'b00));
        check_eq({tag, ".chg"}, 32'(s_fault_chg), 32'(chg));
        check_eq({tag, ".cnt"}, 32'(s_fault_cnt), 32'(cnt));
    endtask

    initial begin
        pulse_reset();
        #1;
        check_s("reset", 2'b00, 1'b0, 16'd0);
        check_eq("reset.m_lf", 32'(m_link_fault), 32'h0);
        check_eq("reset.m_cnt", 32'(m_fault_cnt), 32'h0);
        check_eq("reset.m_any", 32'(m_any_fault), 32'h0);

        // Three local sequences then idle: never qualifies.
        for (int i = 0; i < 3; i++) s_col(1'b1, 1'b1, 2'b01);
        check_s("three_seq", 2'b00, 1'b0, 16'd0);
        for (int i = 0; i < 128; i++) s_col(1'b1, 1'b0, 2'b00);
        check_s("three_idle", 2'b00, 1'b0, 16'd0);

        // Four local sequences: fault on the edge sampling the 4th.
        for (int i = 0; i < 3; i++) s_col(1'b1, 1'b1, 2'b01);
        check_s("pre_fault", 2'b00, 1'b0, 16'd0);
        s_col(1'b1, 1'b1, 2'b01);
        check_s("local_fault", 2'b01, 1'b1, 16'd1);

        // 127 idle columns with ignored (col_valid=0) columns interleaved.
        for (int i = 0; i < 127; i++) begin
            if (i % 16 == 0) s_col(1'b0, 1'b1, 2'b01);
            s_col(1'b1, 1'b0, 2'b00);
        end
        check_s("idle_127", 2'b01, 1'b0, 16'd1);
        s_col(1'b1, 1'b0, 2'b00);
        check_s("idle_128", 2'b00, 1'b1, 16'd1);

        // Type change local -> remote with no OK gap.
        for (int i = 0; i < 4; i++) s_col(1'b1, 1'b1, 2'b01);
        check_s("local_again", 2'b01, 1'b1, 16'd2);
        for (int i = 0; i < 3; i++) s_col(1'b1, 1'b1, 2'b10);
        check_s("remote_3", 2'b01, 1'b0, 16'd2);
        s_col(1'b1, 1'b1, 2'b10);
        check_s("remote_4", 2'b10, 1'b1, 16'd3);

        // Alternating types never confirm; old fault stays visible.
        for (int i = 0; i < 20; i++) s_col(1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
        check_s("alternate", 2'b10, 1'b0, 16'd3);
        // Last column was remote (seq_cnt=1), three more re-enter FAULT with same value.
        for (int i = 0; i < 3; i++) s_col(1'b1, 1'b1, 2'b10);
        check_s("refault", 2'b10, 1'b0, 16'd4);

        // Invalid type columns count as sequence-free.
        for (int i = 0; i < 127; i++) s_col(1'b1, 1'b1, 2'b11);
        check_s("inval_127", 2'b10, 1'b0, 16'd4);
        s_col(1'b1, 1'b1, 2'b11);
        check_s("inval_128", 2'b00, 1'b1, 16'd4);
        for (int i = 0; i < 200; i++) s_col(1'b1, 1'b1, 2'b11);
        check_s("inval_200", 2'b00, 1'b0, 16'd4);

        // Reset mid-count discards partial progress.
        for (int i = 0; i < 3; i++) s_col(1'b1, 1'b1, 2'b01);
        s_col(1'b0, 1'b0, 2'b00);
        pulse_reset();
        #1;
        check_s("mid_reset", 2'b00, 1'b0, 16'd0);
        s_col(1'b1, 1'b1, 2'b01);
        check_s("post_reset_1", 2'b00, 1'b0, 16'd0);
        s_col(1'b1, 1'b1, 2'b01);
        s_col(1'b1, 1'b1, 2'b01);
        check_s("post_reset_3", 2'b00, 1'b0, 16'd0);
        s_col(1'b0, 1'b0, 2'b00);

        // Channel 2 of the 4-channel instance: five fault entries, counter saturates.
        for (int k = 0; k < 5; k++) begin
            logic [7:0] t;
            t = (k % 2 == 0) ? 8'h10 : 8'h20;
            m_col(4'b0100, 4'b0100, t, 4'b0000);
            m_col(4'b0100, 4'b0100, t, 4'b0000);
            if (k == 0) begin
                check_eq("m_first.lf", 32'(m_link_fault), 32'h10);
                check_eq("m_first.chg", 32'(m_fault_chg), 32'h4);
                check_eq("m_first.cnt", 32'(m_fault_cnt), 32'h10);
            end
        end
        check_eq("m_sat.lf", 32'(m_link_fault), 32'h10);
        check_eq("m_sat.cnt", 32'(m_fault_cnt), 32'h30);
        check_eq("m_sat.any", 32'(m_any_fault), 32'h1);
        check_eq("m_sat.rf", 32'(m_send_rf), 32'h4);

        // Clear coinciding with an increment wins.
        m_col(4'b0100, 4'b0100, 8'h20, 4'b0000);
        m_col(4'b0100, 4'b0100, 8'h20, 4'b0100);
        check_eq("m_clr.lf", 32'(m_link_fault), 32'h20);
        check_eq("m_clr.idle", 32'(m_send_idle), 32'h4);
        check_eq("m_clr.cnt", 32'(m_fault_cnt), 32'h00);

        // Channel 0 faults independently; channel 2 unaffected.
        m_col(4'b0001, 4'b0001, 8'h01, 4'b0000);
        m_col(4'b0001, 4'b0001, 8'h01, 4'b0000);
        check_eq("m_ch0.lf", 32'(m_link_fault), 32'h21);
        check_eq("m_ch0.cnt", 32'(m_fault_cnt), 32'h01);
        m_col(4'b0000, 4'b0000, 8'h00, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
